// File: rtl/stabilizer_array_sequencer_if.sv
// Command, row-handshake and array-control bundle between the gate-stream
// front end, the stabilizer array sequencer and the array datapath.
interface stabilizer_array_sequencer_if;
  // command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_gate_type;
  logic [31:0] cmd_qubit_pos;
  logic [31:0] cmd_qubit_pos2;
  // row load / scan handshakes
  logic        row_in_valid;
  logic        row_in_ready;
  logic        row_out_valid;
  logic        row_out_ack;
  // array controls
  logic        rst_new;
  logic        ld_reg;
  logic [1:0]  shift_rotate_array;
  logic        ld_gate_info;
  logic [1:0]  gate_type;
  logic [31:0] qubit_pos;
  logic [31:0] qubit_pos2;
  // status
  logic        busy;
  logic        done;
  logic        err;

  // front end / environment side
  modport master (
    output cmd_valid, cmd_op, cmd_gate_type, cmd_qubit_pos, cmd_qubit_pos2,
    output row_in_valid, row_out_ack,
    input  cmd_ready, row_in_ready, row_out_valid,
    input  rst_new, ld_reg, shift_rotate_array, ld_gate_info,
    input  gate_type, qubit_pos, qubit_pos2, busy, done, err
  );

  // sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_gate_type, cmd_qubit_pos, cmd_qubit_pos2,
    input  row_in_valid, row_out_ack,
    output cmd_ready, row_in_ready, row_out_valid,
    output rst_new, ld_reg, shift_rotate_array, ld_gate_info,
    output gate_type, qubit_pos, qubit_pos2, busy, done, err
  );
endinterface

// File: rtl/stabilizer_array_sequencer.sv
// Command-driven sequencer for the stabilizer-matrix register array.
// CLEAR wipes the array, LOAD shifts in num_qubit rows, GATE rotates the
// target column to position 0 (ALIGN), scans every row past the processing
// unit (SCAN) and rotates the columns back (RESTORE). SCAN alone just cycles
// the rows through the processing unit.
module stabilizer_array_sequencer #(
  parameter int num_qubit = 4,
  parameter int CNT_W     = $clog2(num_qubit) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  stabilizer_array_sequencer_if.slave   bus
);

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_GATE  = 2'd2;
  localparam logic [1:0] OP_SCAN  = 2'd3;

  localparam logic [1:0] SRA_SHIFT_IN = 2'd0;
  localparam logic [1:0] SRA_ROT_DOWN = 2'd1;
  localparam logic [1:0] SRA_ROT_LEFT = 2'd2;

  localparam logic [CNT_W-1:0] NQ       = CNT_W'(num_qubit);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(num_qubit - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    ALIGN,
    SCAN,
    RESTORE,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] row_cnt_reg, row_cnt_next;
  logic [CNT_W-1:0] rot_cnt_reg, rot_cnt_next;
  logic [CNT_W-1:0] k_reg, k_next;        // target column of the current GATE
  logic             gate_reg, gate_next;  // current operation came from GATE

  // unmasked decodes; reset masking is applied at the port assignments
  logic        cmd_ready_c;
  logic        row_in_ready_c;
  logic        row_out_valid_c;
  logic        ld_reg_c;
  logic [1:0]  sra_c;
  logic        ld_gate_info_c;
  logic [1:0]  gate_type_c;
  logic [31:0] qubit_pos_c;
  logic [31:0] qubit_pos2_c;
  logic        done_c;
  logic        err_c;

  logic             pos_illegal;
  logic [CNT_W-1:0] restore_last;

  assign pos_illegal  = (bus.cmd_qubit_pos >= 32'(num_qubit));
  // RESTORE runs num_qubit-k cycles; this is the index of its final cycle
  assign restore_last = NQ - k_reg - CNT_W'(1);

  // state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      row_cnt_reg <= '0;
      rot_cnt_reg <= '0;
      k_reg       <= '0;
      gate_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      row_cnt_reg <= row_cnt_next;
      rot_cnt_reg <= rot_cnt_next;
      k_reg       <= k_next;
      gate_reg    <= gate_next;
    end
  end

  // next-state and control decode
  always_comb begin
    state_next      = state_reg;
    row_cnt_next    = row_cnt_reg;
    rot_cnt_next    = rot_cnt_reg;
    k_next          = k_reg;
    gate_next       = gate_reg;
    cmd_ready_c     = 1'b0;
    row_in_ready_c  = 1'b0;
    row_out_valid_c = 1'b0;
    ld_reg_c        = 1'b0;
    sra_c           = SRA_SHIFT_IN;
    ld_gate_info_c  = 1'b0;
    gate_type_c     = 2'd0;
    qubit_pos_c     = 32'd0;
    qubit_pos2_c    = 32'd0;
    done_c          = 1'b0;
    err_c           = 1'b0;

    case (state_reg)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_CLEAR: state_next = CLEAR;
            OP_LOAD: begin
              state_next   = LOAD;
              row_cnt_next = '0;
            end
            OP_SCAN: begin
              state_next   = SCAN;
              row_cnt_next = '0;
              gate_next    = 1'b0;
              k_next       = '0;
            end
            OP_GATE: begin
              if (pos_illegal) begin
                // rejected: flag it and stay put with no array activity
                err_c = 1'b1;
              end else begin
                ld_gate_info_c = 1'b1;
                gate_type_c    = bus.cmd_gate_type;
                qubit_pos_c    = bus.cmd_qubit_pos;
                qubit_pos2_c   = bus.cmd_qubit_pos2;
                k_next         = bus.cmd_qubit_pos[CNT_W-1:0];
                gate_next      = 1'b1;
                rot_cnt_next   = '0;
                row_cnt_next   = '0;
                // column 0 is already aligned, go straight to scanning
                state_next     = (bus.cmd_qubit_pos[CNT_W-1:0] != '0) ? ALIGN : SCAN;
              end
            end
            default: state_next = IDLE;
          endcase
        end
      end

      CLEAR: state_next = DONE;

      LOAD: begin
        row_in_ready_c = 1'b1;
        if (bus.row_in_valid) begin
          ld_reg_c     = 1'b1;
          sra_c        = SRA_SHIFT_IN;
          row_cnt_next = row_cnt_reg + CNT_W'(1);
          if (row_cnt_reg == LAST_ROW) begin
            state_next = DONE;
          end
        end
      end

      ALIGN: begin
        ld_reg_c     = 1'b1;
        sra_c        = SRA_ROT_LEFT;
        rot_cnt_next = rot_cnt_reg + CNT_W'(1);
        if (rot_cnt_reg == k_reg - CNT_W'(1)) begin
          state_next   = SCAN;
          row_cnt_next = '0;
        end
      end

      SCAN: begin
        row_out_valid_c = 1'b1;
        if (bus.row_out_ack) begin
          ld_reg_c     = 1'b1;
          sra_c        = SRA_ROT_DOWN;
          row_cnt_next = row_cnt_reg + CNT_W'(1);
          if (row_cnt_reg == LAST_ROW) begin
            // a full turn of row rotations leaves row order unchanged
            if (gate_reg && (k_reg != '0)) begin
              state_next   = RESTORE;
              rot_cnt_next = '0;
            end else begin
              state_next = DONE;
            end
          end
        end
      end

      RESTORE: begin
        // k left-rotations plus num_qubit-k more make a full column turn
        ld_reg_c     = 1'b1;
        sra_c        = SRA_ROT_LEFT;
        rot_cnt_next = rot_cnt_reg + CNT_W'(1);
        if (rot_cnt_reg == restore_last) begin
          state_next = DONE;
        end
      end

      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // reset masks every control except the array clear and the ready flag
  assign bus.cmd_ready          = rst | cmd_ready_c;
  assign bus.rst_new            = rst | (state_reg == CLEAR);
  assign bus.row_in_ready       = ~rst & row_in_ready_c;
  assign bus.row_out_valid      = ~rst & row_out_valid_c;
  assign bus.ld_reg             = ~rst & ld_reg_c;
  assign bus.shift_rotate_array = rst ? 2'd0 : sra_c;
  assign bus.ld_gate_info       = ~rst & ld_gate_info_c;
  assign bus.gate_type          = rst ? 2'd0 : gate_type_c;
  assign bus.qubit_pos          = rst ? 32'd0 : qubit_pos_c;
  assign bus.qubit_pos2         = rst ? 32'd0 : qubit_pos2_c;
  assign bus.busy               = ~rst & (state_reg != IDLE);
  assign bus.done               = ~rst & done_c;
  assign bus.err                = ~rst & err_c;

endmodule

// File: doc/stabilizer_array_sequencer.md
Name: stabilizer_array_sequencer

Overview:
- Command-driven FSM that sequences the stabilizer-matrix register array: clears it, loads rows, aligns a target qubit column, scans rows through the processing unit, and restores column order.
- Drives the array's rst_new, ld_reg, shift_rotate_array and ld_gate_info controls.
- Sits between the gate-stream front end and the conjugation/canonical-reduction datapath.

Parameters:
- num_qubit, 4, matrix dimension: rows = columns = num_qubit; ≥2.
- CNT_W, $clog2(num_qubit)+1, width of the internal row and rotation counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0 CLEAR, 1 LOAD, 2 GATE, 3 SCAN.
- cmd_gate_type  in  2  gate type for GATE.
- cmd_qubit_pos  in  32  target column for GATE.
- cmd_qubit_pos2  in  32  second qubit for GATE; passed through, not range-checked.
- row_in_valid  in  1  upstream row available (LOAD).
- row_in_ready  out  1  sequencer accepts a row.
- row_out_valid  out  1  last array row is valid for processing (SCAN phase).
- row_out_ack  in  1  processing unit consumed the row.
- rst_new  out  1  array clear.
- ld_reg  out  1  array load enable.
- shift_rotate_array  out  2  0 shift-in, 1 rotate down, 2 rotate left.
- ld_gate_info  out  1  gate-info latch strobe.
- gate_type  out  2  gate type to array.
- qubit_pos  out  32  target qubit to array.
- qubit_pos2  out  32  second qubit to array.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal-command pulse.

Behaviour:
- States: IDLE, CLEAR, LOAD, ALIGN, SCAN, RESTORE, DONE.
- Reset: rst is synchronous; on rst the FSM goes to IDLE and both counters clear to 0.
- rst_new = rst OR (state==CLEAR), so the array is also cleared during reset.
- All other outputs are combinational decodes of state and inputs; while rst is high they are 0, except cmd_ready=1 because the FSM is in IDLE.
- Reset mid-operation aborts the operation: no done, no restore.

IDLE:
- cmd_ready=1. Acceptance = cmd_valid in IDLE.
- CLEAR → CLEAR.
- LOAD → LOAD, row_cnt=0.
- SCAN → SCAN, row_cnt=0.
- GATE with cmd_qubit_pos ≥ num_qubit: err=1 in the same cycle, stay IDLE, no other output asserted.
- GATE legal: in the acceptance cycle ld_gate_info=1, with gate_type/qubit_pos/qubit_pos2 driven straight from the cmd_* inputs. Capture k = cmd_qubit_pos[CNT_W-1:0].
  - k≠0 → ALIGN, rot_cnt=0.
  - k=0 → SCAN.
- Outside that acceptance cycle, gate_type/qubit_pos/qubit_pos2 are 0.

CLEAR:
- One cycle with rst_new=1, then DONE.

LOAD:
- row_in_ready=1.
- Each cycle with row_in_valid=1: ld_reg=1, shift_rotate_array=0 in that cycle; row_cnt increments.
- The num_qubit-th accepted row moves the FSM to DONE.
- Gaps in row_in_valid stall with no array activity.

ALIGN:
- ld_reg=1, shift_rotate_array=2 every cycle for exactly k cycles, then SCAN.

SCAN:
- row_out_valid=1.
- Cycle with row_out_ack=1: ld_reg=1, shift_rotate_array=1; row_cnt increments.
- After num_qubit acks the array is back in its original row order.
  - Exit to RESTORE if k≠0 and the command was GATE.
  - Exit to DONE otherwise.
- row_out_ack outside SCAN is ignored.

RESTORE:
- ld_reg=1, shift_rotate_array=2 for num_qubit−k cycles, then DONE. Column order is restored in total.

DONE:
- done=1 for one cycle, then IDLE.
- The next command can be accepted the cycle after DONE.

General rules:
- ld_reg is never asserted outside LOAD, ALIGN, SCAN and RESTORE.
- shift_rotate_array=0 whenever ld_reg=0.
- Latency, GATE with no stalls: 1 (accept) + k + num_qubit + (num_qubit−k if k≠0) + 1 (DONE) cycles.

Test Plan:
- Reset, then CLEAR → rst_new high for 1 cycle (it is also high during rst); done one cycle later; busy high exactly 2 cycles.
- LOAD with num_qubit=4, row_in_valid pattern 1,0,1,1,0,1 → ld_reg with shift_rotate_array=0 in exactly the four valid cycles; done one cycle after the 4th accept.
- GATE qubit_pos=1, gate_type=2, qubit_pos2=3, ack held high → accept-cycle ld_gate_info=1 with outputs 2/1/3; then 1 rotate-left, 4 rotate-down, 3 rotate-left cycles; done at cycle 10.
- GATE qubit_pos=0, row_out_ack delayed 3 cycles per row → no rotate-left ever; 4 rotate-downs, each coincident with an ack; row_out_valid held between acks.
- GATE qubit_pos=4 (num_qubit=4) → err pulse in the acceptance cycle; no ld_reg, no ld_gate_info; FSM stays IDLE with cmd_ready=1.
- rst asserted during SCAN after 2 acks → next cycle IDLE, all controls 0 except cmd_ready=1; no done; rst_new high while rst is high.
